fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 13 +
 rtl/fifo_rd_stream_if.sv | 28 ++
 rtl/fifo_rd_stream_skid_buf_2.sv | 53 +++++
 rtl/fifo_rd_stream.sv | 61 ++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and defaults for the FIFO read-side streamer and the benches that drive it.
package fifo_rd_stream_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Signal bundle between a FIFO read port, the streamer and its downstream consumer.
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
  input logic clk
);

  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_underflow;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;

  modport fifo_side (
    input  clk, fifo_rd_en,
    output fifo_empty, fifo_data_out, fifo_underflow
  );

  modport sink (
    input  clk, m_valid, m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_stream_skid_buf_2.sv
// Two-entry in-order buffer: writes land in the tail slot, the head slot drives the output.
module skid_buf_2
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  occ_t             occ_q;
  occ_t             occ_n;

  always_comb begin
    occ_n = occ_q;
    unique case ({wr_en, rd_en})
      2'b10: occ_n = (occ_q == EMPTY) ? ONE : TWO;
      2'b01: occ_n = (occ_q == TWO) ? ONE : EMPTY;
      default: occ_n = occ_q;
    endcase
  end

  // Storage is cleared too so the output word reads zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      occ_q <= EMPTY;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= ~tail;
      end
      if (rd_en) head <= ~head;
      occ_q <= occ_n;
    end
  end

  assign rd_data = mem[head];
  assign valid   = (occ_q != EMPTY);
  assign occ     = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO read port (one-cycle read latency) into a valid/ready stream at full rate.
// Reads are only issued when the two-entry buffer is guaranteed room for the returning word.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  err_underflow
);

  logic       run;
  logic       inflight;
  logic       pop;
  logic [1:0] occ;
  logic [2:0] level;

  assign pop   = m_valid & m_ready;
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // run holds reads off until the first full cycle after reset is released.
  assign fifo_rd_en = rst_n & run & ~fifo_empty & (level < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      inflight      <= 1'b0;
      words_out     <= '0;
      err_underflow <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= fifo_rd_en;
      if (pop) words_out <= words_out + CNT_WIDTH'(1);
      if (fifo_underflow) err_underflow <= 1'b1;
    end
  end

  skid_buf_2 #(
    .WIDTH(FIFO_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight),
    .wr_data (fifo_data_out),
    .rd_en   (pop),
    .rd_data (m_data),
    .valid   (m_valid),
    .occ     (occ)
  );

endmodule
